// File: rtl/spi_flash_arbiter_pkg.sv
// Shared constants for the two-client M25P16 SPI arbiter: flash opcodes,
// FSM state encodings and the round-robin pick helper.
package spi_flash_arbiter_pkg;

  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CS_SETUP = 3'd1;
  localparam logic [2:0] ST_OPCODE   = 3'd2;
  localparam logic [2:0] ST_ADDR     = 3'd3;
  localparam logic [2:0] ST_READ     = 3'd4;
  localparam logic [2:0] ST_FINISH   = 3'd5;
  localparam logic [2:0] ST_HOLD     = 3'd6;

  // A lone request wins outright; on contention the preferred client wins.
  function automatic logic pick_client(input logic [1:0] req, input logic pref);
    return (req == 2'b11) ? pref : req[1];
  endfunction

endpackage

// File: rtl/spi_flash_arbiter_bit_engine.sv
// SPI mode-0 byte shifter: divides CCLK into SPICLK, shifts MOSI out MSB first,
// samples MISO on each SPICLK rise and flags the falling edge that ends a byte.
module spi_flash_arbiter_bit_engine #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       prime,
  input  logic       prime_bit,
  input  logic       load,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       byte_end,
  output logic [7:0] rx_byte
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic          active_reg;
  logic [DW-1:0] div_cnt_reg;
  logic [2:0]    bit_cnt_reg;
  logic [6:0]    tx_sr_reg;
  logic [7:0]    rx_sr_reg;
  logic          half_end;

  assign half_end = active_reg && (div_cnt_reg == DW'(CLK_DIV - 1));
  // Combinational so the owner can chain the next byte with no extra low time.
  assign byte_end = half_end && sclk && (bit_cnt_reg == 3'd7);
  assign rx_byte  = rx_sr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_reg  <= 1'b0;
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      tx_sr_reg   <= '0;
      rx_sr_reg   <= '0;
      sclk        <= 1'b0;
      mosi        <= 1'b0;
    end else if (load) begin
      active_reg  <= 1'b1;
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      tx_sr_reg   <= tx_byte[6:0];
      mosi        <= tx_byte[7];
      sclk        <= 1'b0;
    end else if (prime) begin
      mosi <= prime_bit;
    end else if (half_end) begin
      div_cnt_reg <= '0;
      if (!sclk) begin
        sclk      <= 1'b1;
        rx_sr_reg <= {rx_sr_reg[6:0], miso};
      end else begin
        sclk <= 1'b0;
        if (bit_cnt_reg == 3'd7) begin
          active_reg <= 1'b0;
          mosi       <= 1'b0;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
          mosi        <= tx_sr_reg[6];
          tx_sr_reg   <= {tx_sr_reg[5:0], 1'b0};
        end
      end
    end else if (active_reg) begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/spi_flash_arbiter.sv
// Two-client round-robin arbiter for the M25P16 SPI flash: latches the winner's
// command, sequences chip_select/opcode/address/read bytes and streams bytes back.
module spi_flash_arbiter
  import spi_flash_arbiter_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int RX_LEN_W = 4,
  parameter int CS_HOLD  = 4
) (
  input  logic                  CCLK,
  input  logic                  reset_n,
  input  logic [1:0]            req,
  input  logic [15:0]           req_opcode,
  input  logic [47:0]           req_addr,
  input  logic [1:0]            req_addr_en,
  input  logic [2*RX_LEN_W-1:0] req_rx_len,
  output logic [1:0]            grant,
  output logic [1:0]            done,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  SPICLK,
  output logic                  SPIMOSI,
  input  logic                  SPIMISO,
  output logic                  chip_select
);

  localparam int HW = $clog2(CS_HOLD + 1);

  logic [7:0]          opc_c  [2];
  logic [23:0]         addr_c [2];
  logic [RX_LEN_W-1:0] len_c  [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_client
    assign opc_c[gi]  = req_opcode[8*gi +: 8];
    assign addr_c[gi] = req_addr[24*gi +: 24];
    assign len_c[gi]  = req_rx_len[RX_LEN_W*gi +: RX_LEN_W];
  end

  logic [2:0]          state_reg;
  logic [2:0]          phase_next;
  logic                pref_reg;
  logic [7:0]          opcode_reg;
  logic [23:0]         addr_reg;
  logic                addr_en_reg;
  logic [RX_LEN_W-1:0] rx_len_reg;
  logic [RX_LEN_W-1:0] byte_cnt_reg;
  logic [1:0]          addr_idx_reg;
  logic [HW-1:0]       hold_cnt_reg;
  logic                win;
  logic                eng_load;
  logic [7:0]          tx_next;
  logic                byte_end;
  logic [7:0]          eng_rx;

  assign win = pick_client(req, pref_reg);

  spi_flash_arbiter_bit_engine #(.CLK_DIV(CLK_DIV)) u_engine (
    .clk      (CCLK),
    .rst_n    (reset_n),
    .prime    ((state_reg == ST_IDLE) && (req != 2'b00)),
    .prime_bit(opc_c[win][7]),
    .load     (eng_load),
    .tx_byte  (tx_next),
    .miso     (SPIMISO),
    .sclk     (SPICLK),
    .mosi     (SPIMOSI),
    .byte_end (byte_end),
    .rx_byte  (eng_rx)
  );

  // Decide at each byte boundary which byte (if any) follows; read bytes shift out zeros.
  always_comb begin
    eng_load   = 1'b0;
    tx_next    = 8'h00;
    phase_next = state_reg;
    case (state_reg)
      ST_CS_SETUP: begin
        eng_load   = 1'b1;
        tx_next    = opcode_reg;
        phase_next = ST_OPCODE;
      end
      ST_OPCODE, ST_ADDR: begin
        if (byte_end) begin
          if (state_reg == ST_OPCODE && addr_en_reg) begin
            eng_load   = 1'b1;
            tx_next    = addr_reg[23:16];
            phase_next = ST_ADDR;
          end else if (state_reg == ST_ADDR && addr_idx_reg != 2'd2) begin
            eng_load = 1'b1;
            tx_next  = (addr_idx_reg == 2'd0) ? addr_reg[15:8] : addr_reg[7:0];
          end else if (rx_len_reg != '0) begin
            eng_load   = 1'b1;
            phase_next = ST_READ;
          end else begin
            phase_next = ST_FINISH;
          end
        end
      end
      ST_READ: begin
        if (byte_end) begin
          if (byte_cnt_reg + 1'b1 == rx_len_reg) phase_next = ST_FINISH;
          else eng_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CCLK or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      pref_reg     <= 1'b0;
      opcode_reg   <= '0;
      addr_reg     <= '0;
      addr_en_reg  <= 1'b0;
      rx_len_reg   <= '0;
      byte_cnt_reg <= '0;
      addr_idx_reg <= '0;
      hold_cnt_reg <= '0;
      grant        <= 2'b00;
      done         <= 2'b00;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      busy         <= 1'b0;
      chip_select  <= 1'b1;
    end else begin
      done     <= 2'b00;
      rx_valid <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req != 2'b00) begin
            opcode_reg   <= opc_c[win];
            addr_reg     <= addr_c[win];
            addr_en_reg  <= req_addr_en[win];
            rx_len_reg   <= len_c[win];
            byte_cnt_reg <= '0;
            addr_idx_reg <= '0;
            grant        <= win ? 2'b10 : 2'b01;
            busy         <= 1'b1;
            chip_select  <= 1'b0;
            state_reg    <= ST_CS_SETUP;
            if (req == 2'b11) pref_reg <= ~win;
          end
        end
        ST_FINISH: begin
          chip_select  <= 1'b1;
          done         <= grant;
          grant        <= 2'b00;
          hold_cnt_reg <= '0;
          state_reg    <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_cnt_reg == HW'(CS_HOLD - 1)) begin
            busy      <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= phase_next;
          if (byte_end && state_reg == ST_ADDR) addr_idx_reg <= addr_idx_reg + 2'd1;
          if (byte_end && state_reg == ST_READ) begin
            rx_data      <= eng_rx;
            rx_valid     <= 1'b1;
            byte_cnt_reg <= byte_cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
